// File: rtl/alu_share_pkg.sv
// Shared types and widths for the shared adder/multiplier scheduler.
// Imported by alu_share_sched and its round-robin arbiter.
package alu_share_pkg;

   typedef enum logic {
      OP_ADD  = 1'b0,
      OP_MULT = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   localparam int OPND_W = 8;
   localparam int MULT_W = 4;
   localparam int RES_W  = 9;
   localparam int PERF_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker with its own pointer register.
// Search starts one past the last winner; the pointer moves only on advance.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_q;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (int'(ptr_q) + k) % N;
         if (!found && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end

   // Reset to the last slot so requester 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= IW'(N - 1);
      end else if (advance) begin
         ptr_q <= grant_idx;
      end
   end

endmodule

// File: rtl/alu_share_sched.sv
// Shares one 8-bit adder and one 4x4 multiplier between NUM_REQ requesters.
// Define ALU_SHARE_SCHED_PERF_EN for per-requester grant and stall counters.
module alu_share_sched
   import alu_share_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_op,
   input  logic [NUM_REQ*OPND_W-1:0] req_a,
   input  logic [NUM_REQ*OPND_W-1:0] req_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [RES_W-1:0]          out_result,
   output logic [ID_W-1:0]           out_id
`ifdef ALU_SHARE_SCHED_PERF_EN
   ,
   output logic [NUM_REQ*PERF_W-1:0] perf_grant_cnt,
   output logic [PERF_W-1:0]         perf_stall_cnt
`endif
);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [OPND_W-1:0]   a_q, a_d;
   logic [OPND_W-1:0]   b_q, b_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [RES_W-1:0]    res_q, res_d;
   logic [ID_W-1:0]     oid_q, oid_d;
   logic                accept;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     gidx;
   logic [2*MULT_W-1:0] prod;
   logic [RES_W-1:0]    sum;
   logic [RES_W-1:0]    alu;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (gidx)
   );

   assign prod = {{MULT_W{1'b0}}, a_q[MULT_W-1:0]}
               * {{MULT_W{1'b0}}, b_q[MULT_W-1:0]};
   assign sum  = {1'b0, a_q} + {1'b0, b_q};
   assign alu  = (op_q == OP_MULT) ? {1'b0, prod} : sum;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      id_d    = id_q;
      res_d   = res_q;
      oid_d   = oid_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: accept = |req_valid;
         EXEC: begin
            res_d   = alu;
            oid_d   = id_q;
            state_d = RESP;
         end
         RESP: begin
            if (out_ready) begin
               accept  = |req_valid;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A same-cycle accept in RESP chains straight into the next op.
      if (accept) begin
         op_d    = op_e'(req_op[gidx]);
         a_d     = req_a[int'(gidx)*OPND_W +: OPND_W];
         b_d     = req_b[int'(gidx)*OPND_W +: OPND_W];
         id_d    = gidx;
         state_d = EXEC;
      end
   end

   assign req_ready  = accept ? grant : '0;
   assign out_valid  = (state_q == RESP);
   assign out_result = res_q;
   assign out_id     = oid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= '0;
         res_q   <= '0;
         oid_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         id_q    <= id_d;
         res_q   <= res_d;
         oid_q   <= oid_d;
      end
   end

`ifdef ALU_SHARE_SCHED_PERF_EN
   logic [PERF_W-1:0] stall_q;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
      logic [PERF_W-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (req_ready[i] && req_valid[i] && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
      assign perf_grant_cnt[i*PERF_W +: PERF_W] = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (state_q == RESP && !out_ready && stall_q != '1) begin
         stall_q <= stall_q + 1'b1;
      end
   end
   assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched (NUM_REQ=2).
// Perf counter checks compile in when ALU_SHARE_SCHED_PERF_EN is defined.
module tb_alu_share_sched;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  out_result;
   logic [0:0]  out_id;
`ifdef ALU_SHARE_SCHED_PERF_EN
   logic [31:0] perf_grant_cnt;
   logic [15:0] perf_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   alu_share_sched #(.NUM_REQ(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_id     (out_id)
`ifdef ALU_SHARE_SCHED_PERF_EN
      ,
      .perf_grant_cnt (perf_grant_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_result !== 9'h000 || out_id !== 1'b0) begin
         errors++;
         $display("FAIL rst_out: got %h/%b want 000/0", out_result, out_id);
      end
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL rst_ready: got %b want 00", req_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, req_ready, out_result} !== 12'h000) begin
            errors++;
            $display("FAIL idle_%0d: got v=%b r=%b res=%h want 0",
                     i, out_valid, req_ready, out_result);
         end
      end
   endtask

   task automatic test_add();
      @(posedge clk);
      #1;
      req_valid = 2'b01;
      req_op    = 2'b00;
      req_a     = 16'h00FF;
      req_b     = 16'h0001;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL add_ready: got %b want 01", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL add_exec: out_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 9'h100 || out_id !== 1'b0) begin
         errors++;
         $display("FAIL add_res: got v=%b res=%h id=%b want 1/100/0",
                  out_valid, out_result, out_id);
      end
   endtask

   task automatic test_mult();
      @(posedge clk);
      #1;
      req_valid = 2'b10;
      req_op    = 2'b10;
      req_a     = 16'hF700;
      req_b     = 16'h3C00;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL mult_ready: got %b want 10", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 9'd84 || out_id !== 1'b1) begin
         errors++;
         $display("FAIL mult_res: got v=%b res=%0d id=%b want 1/84/1",
                  out_valid, out_result, out_id);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] er [8] = '{2'b01, 2'b00, 2'b10, 2'b00,
                             2'b01, 2'b00, 2'b10, 2'b00};
      logic       ev [8] = '{1'b0, 1'b0, 1'b1, 1'b0,
                             1'b1, 1'b0, 1'b1, 1'b0};
      logic       ei [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b0};
      logic [8:0] rr [8] = '{9'h0, 9'h0, 9'h030, 9'h0,
                             9'h00B, 9'h0, 9'h030, 9'h0};
      @(posedge clk);
      #1;
      req_valid = 2'b11;
      req_op    = 2'b00;
      req_a     = 16'h0510;
      req_b     = 16'h0620;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== er[c] || out_valid !== ev[c]) begin
            errors++;
            $display("FAIL b2b_c%0d: got r=%b v=%b want r=%b v=%b",
                     c, req_ready, out_valid, er[c], ev[c]);
         end
         if (ev[c]) begin
            checks++;
            if (out_id !== ei[c] || out_result !== rr[c]) begin
               errors++;
               $display("FAIL b2b_res%0d: got id=%b res=%h want %b/%h",
                        c, out_id, out_result, ei[c], rr[c]);
            end
         end
         @(posedge clk);
         #1;
      end
      req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_id !== 1'b1 || out_result !== 9'h00B ||
          req_ready !== 2'b00) begin
         errors++;
         $display("FAIL b2b_last: got v=%b id=%b res=%h r=%b want 1/1/00B/00",
                  out_valid, out_id, out_result, req_ready);
      end
   endtask

   task automatic test_backpressure();
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      req_valid = 2'b11;
      req_op    = 2'b10;
      req_a     = 16'h0F80;
      req_b     = 16'h0F80;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL bp_ready0: got %b want 01", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 2'b10;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL bp_exec: req_ready got %b want 00", req_ready);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_result !== 9'h100 ||
             out_id !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b res=%h id=%b r=%b want 1/100/0/00",
                     i, out_valid, out_result, out_id, req_ready);
         end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b10 || out_valid !== 1'b1 || out_result !== 9'h100) begin
         errors++;
         $display("FAIL bp_release: got r=%b v=%b res=%h want 10/1/100",
                  req_ready, out_valid, out_result);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_exec2: out_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 9'h0E1 || out_id !== 1'b1) begin
         errors++;
         $display("FAIL bp_mult: got v=%b res=%h id=%b want 1/0E1/1",
                  out_valid, out_result, out_id);
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      #1;
      req_valid = 2'b01;
      req_op    = 2'b00;
      req_a     = 16'h0001;
      req_b     = 16'h0002;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rm_ready: got %b want 01", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_result !== 9'h000 || out_id !== 1'b0) begin
         errors++;
         $display("FAIL rm_exec_rst: got v=%b res=%h id=%b want 0/000/0",
                  out_valid, out_result, out_id);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_nopulse%0d: out_valid got %b want 0", i, out_valid);
         end
      end
      @(posedge clk);
      #1;
      req_valid = 2'b01;
      req_a     = 16'h0003;
      req_b     = 16'h0004;
      out_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 9'h007) begin
         errors++;
         $display("FAIL rm_resp: got v=%b res=%h want 1/007", out_valid, out_result);
      end
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_result !== 9'h000) begin
         errors++;
         $display("FAIL rm_resp_rst: got v=%b res=%h want 0/000",
                  out_valid, out_result);
      end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 2'b11;
      req_a     = 16'h0909;
      req_b     = 16'h0909;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rm_restart: got %b want 01", req_ready);
      end
      @(posedge clk);
      #1 req_valid = 2'b00;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== 9'h012 || out_id !== 1'b0) begin
         errors++;
         $display("FAIL rm_after: got v=%b res=%h id=%b want 1/012/0",
                  out_valid, out_result, out_id);
      end
   endtask

`ifdef ALU_SHARE_SCHED_PERF_EN
   task automatic test_perf();
      @(posedge clk);
      #1 rst_n = 1'b0;
      req_valid = 2'b00;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         req_valid = 2'b01;
         req_a     = 16'h0001;
         req_b     = 16'h0001;
         @(posedge clk);
         #1 req_valid = 2'b00;
         repeat (2) @(posedge clk);
      end
      @(negedge clk);
      checks++;
      if (perf_grant_cnt !== 32'h0000_0003 || perf_stall_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL perf_cnt: got g=%h s=%h want 00000003/0000",
                  perf_grant_cnt, perf_stall_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_add();
      test_mult();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
`ifdef ALU_SHARE_SCHED_PERF_EN
      test_perf();
`endif
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
